bullet_pool: RTL and testbench
==============================

BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Clk  in  1  system clock; all state on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 frame_clk  in  1  vertical-sync-rate level signal; a rising edge (detected against its value registered on Clk) is one frame tick.
REQ-004 fire  in  1  shoot button level; a rising edge is one fire request.
REQ-005 TankX, TankY  in  10 each  firing tank centre, pixels.
REQ-006 sin, cos  in  8 each  signed Q1.6 heading (64 = +1.0), same encoding the colour mapper rotates by.
REQ-007 Bullet1X..Bullet3X, Bullet1Y..Bullet3Y  out  10 each  bullet centres, pixels (integer part of position).
REQ-008 Bullet1S..Bullet3S  out  10 each  half-size; constant BULLET_SIZE.
REQ-009 is_bullet1_active..is_bullet3_active  out  1 each  slot live.
REQ-010 free_slots  out  2  count of inactive slots.

Function
REQ-011 Controller FSM SHALL have states IDLE, MOVE, SPAWN: IDLE->MOVE on frame tick; MOVE->SPAWN after one cycle; SPAWN->IDLE after one cycle.
REQ-012 Fire edges SHALL set a pending flag held until served in SPAWN; multiple edges before service SHALL collapse to one request.
REQ-013 Fire edge coinciding with a frame tick SHALL set pending and be served in that same frame's SPAWN.
REQ-014 Positions SHALL be held as 10.6 unsigned fixed point; velocity as signed 10.6: vx = cos*SPEED, vy = -sin*SPEED (SPEED = 4 px/frame).
REQ-015 In MOVE each active slot SHALL add its velocity to its position and decrement its 10-bit life counter.
REQ-016 Life counter reaching 0 in MOVE SHALL clear the slot's active bit in that MOVE cycle.
REQ-017 In SPAWN, if pending, cooldown = 0 and a slot is free, the lowest-index free slot SHALL load position {TankX,6'b0},{TankY,6'b0}, velocity from current sin/cos, life = LIFETIME (600), set active, clear pending, load cooldown = 8.
REQ-018 Pending request with no free slot or nonzero cooldown SHALL be dropped (pending cleared).
REQ-019 A slot retired in MOVE SHALL be allocatable in the immediately following SPAWN.
REQ-020 Cooldown SHALL decrement once per frame in MOVE, saturating at 0.
REQ-021 Outputs SHALL be registered: MOVE results visible at SPAWN cycle, spawn visible the cycle after SPAWN.
REQ-022 Edge handling: next position outside X 0..639 or Y 0..479 (underflow detected via sign of the signed sum) handled per REQ-026/027.
REQ-023 Inactive slots SHALL hold last position; colour mapper gates on active bit.

Reset
REQ-024 Reset SHALL force state IDLE, all active bits 0, positions/velocities 0, life 0, cooldown 0, pending 0, edge-detect registers 0, free_slots = 3, BulletNS = BULLET_SIZE.
REQ-025 Reset asserted mid-MOVE or mid-SPAWN SHALL abandon the frame; no partial update survives.

Configuration
REQ-026 With BULLET_BOUNCE_EN defined: on crossing an edge the offending velocity component SHALL negate and the coordinate SHALL clamp to that edge.
REQ-027 Without BULLET_BOUNCE_EN: crossing any edge SHALL clear the slot's active bit in that MOVE cycle.

Structure
REQ-028 Shared package tank_pkg SHALL hold NUM_BULLETS = 3, BULLET_SIZE = 2, SPEED, LIFETIME, COOLDOWN, SCREEN_W = 640, SCREEN_H = 480, bullet_t struct {active, x, y, vx, vy, life}.
REQ-029 Per-slot move/bounce/retire arithmetic SHALL live in sub-module bullet_slot, instantiated NUM_BULLETS times; bullet_pool holds FSM, allocator, cooldown.

Verification
REQ-030 Reset, then TankX=320 TankY=240 cos=64 sin=0, one fire edge, one frame -> slot1 active at (320,240), free_slots=2; next frame Bullet1X=324.
REQ-031 Fire edges at frames 0, 10, 20, 30 -> three slots fill in order 1,2,3; fourth dropped, free_slots=0.
REQ-032 Two fire edges 3 frames apart -> second dropped by cooldown; only slot1 active.
REQ-033 Bullet at X=638, vx=+4: with BULLET_BOUNCE_EN -> X=639, vx=-4; without -> is_bullet1_active=0.
REQ-034 Bullet alive 600 frames -> inactive after 600th MOVE; fire same frame -> slot1 reused in SPAWN.
REQ-035 Reset asserted during SPAWN with pending -> all outputs at reset values, no bullet appears next frame.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared constants, controller state encoding and bullet record for the tank game.
package tank_pkg;

  localparam int unsigned NUM_BULLETS = 3;
  localparam int unsigned BULLET_SIZE = 2;
  localparam int unsigned SPEED       = 4;
  localparam int unsigned LIFETIME    = 600;
  localparam int unsigned COOLDOWN    = 8;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SPAWN
  } state_t;

  // Positions are unsigned 10.6, velocities signed 10.6.
  typedef struct packed {
    logic               active;
    logic        [15:0] x;
    logic        [15:0] y;
    logic signed [15:0] vx;
    logic signed [15:0] vy;
    logic        [9:0]  life;
  } bullet_t;

  // Q1.6 heading component scaled to a 10.6 per-frame velocity.
  function automatic logic signed [15:0] heading_vel(input logic signed [7:0] h);
    logic signed [15:0] ext;
    ext = {{8{h[7]}}, h};
    return ext * $signed(16'(SPEED));
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: per-frame move, life countdown and screen-edge handling.
// Edge behaviour selected by BULLET_BOUNCE_EN (bounce) or retire (default).
module bullet_slot
  import tank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              move,
  input  logic              load,
  input  logic [9:0]        load_x,
  input  logic [9:0]        load_y,
  input  logic signed [7:0] load_sin,
  input  logic signed [7:0] load_cos,
  output logic              active,
  output logic [9:0]        pos_x,
  output logic [9:0]        pos_y
);

  bullet_t            st;
  bullet_t            nxt;
  logic signed [17:0] sx;
  logic signed [17:0] sy;
  logic               ux, ox, uy, oy;
  logic               expire;

  always_comb begin
    sx = $signed({2'b00, st.x}) + 18'(st.vx);
    sy = $signed({2'b00, st.y}) + 18'(st.vy);
    ux = sx[17];
    uy = sy[17];
    ox = !ux && (sx[16] || (sx[15:6] > 10'(SCREEN_W - 1)));
    oy = !uy && (sy[16] || (sy[15:6] > 10'(SCREEN_H - 1)));
    expire = (st.life <= 10'd1);
  end

  always_comb begin
    nxt = st;
    if (load) begin
      nxt.active = 1'b1;
      nxt.x      = {load_x, 6'b0};
      nxt.y      = {load_y, 6'b0};
      nxt.vx     = heading_vel(load_cos);
      nxt.vy     = -heading_vel(load_sin);
      nxt.life   = 10'(LIFETIME);
    end else if (move && st.active) begin
      nxt.life = (st.life == '0) ? '0 : st.life - 10'd1;
      nxt.x    = sx[15:0];
      nxt.y    = sy[15:0];
`ifdef BULLET_BOUNCE_EN
      if (ux) begin
        nxt.x  = '0;
        nxt.vx = -st.vx;
      end else if (ox) begin
        nxt.x  = {10'(SCREEN_W - 1), 6'b0};
        nxt.vx = -st.vx;
      end
      if (uy) begin
        nxt.y  = '0;
        nxt.vy = -st.vy;
      end else if (oy) begin
        nxt.y  = {10'(SCREEN_H - 1), 6'b0};
        nxt.vy = -st.vy;
      end
      if (expire) nxt.active = 1'b0;
`else
      // Leaving the screen retires the slot at its last on-screen position.
      if (ux || ox || uy || oy) begin
        nxt.x      = st.x;
        nxt.y      = st.y;
        nxt.active = 1'b0;
      end else if (expire) begin
        nxt.active = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) st <= '0;
    else       st <= nxt;
  end

  assign active = st.active;
  assign pos_x  = st.x[15:6];
  assign pos_y  = st.y[15:6];

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool top: frame FSM, fire request latch, slot allocator and cooldown.
// Optional edge bounce via BULLET_BOUNCE_EN (handled inside bullet_slot).
module bullet_pool
  import tank_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [7:0] sin,
  input  logic [7:0] cos,
  output logic [9:0] Bullet1X,
  output logic [9:0] Bullet2X,
  output logic [9:0] Bullet3X,
  output logic [9:0] Bullet1Y,
  output logic [9:0] Bullet2Y,
  output logic [9:0] Bullet3Y,
  output logic [9:0] Bullet1S,
  output logic [9:0] Bullet2S,
  output logic [9:0] Bullet3S,
  output logic       is_bullet1_active,
  output logic       is_bullet2_active,
  output logic       is_bullet3_active,
  output logic [1:0] free_slots
);

  state_t state, state_nxt;
  logic   frame_q, fire_q;
  logic   frame_tick, fire_edge;
  logic   move_en, spawn_en;
  logic   pending;
  logic [3:0] cooldown;
  logic   serve;
  logic   found;

  logic [NUM_BULLETS-1:0] load;
  logic [NUM_BULLETS-1:0] active;
  logic [9:0]             px [NUM_BULLETS];
  logic [9:0]             py [NUM_BULLETS];

  assign frame_tick = frame_clk && !frame_q;
  assign fire_edge  = fire && !fire_q;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = MOVE;
      MOVE:    state_nxt = SPAWN;
      SPAWN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    move_en  = (state == MOVE);
    spawn_en = (state == SPAWN);
  end

  always_comb begin
    free_slots = '0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++)
      if (!active[i]) free_slots = free_slots + 2'd1;
  end

  assign serve = spawn_en && pending && (cooldown == '0) && (free_slots != '0);

  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!found && !active[i]) begin
        load[i] = serve;
        found   = 1'b1;
      end
    end
  end

  // A fresh edge in the SPAWN cycle survives as a new request for the next frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q  <= 1'b0;
      fire_q   <= 1'b0;
      pending  <= 1'b0;
      cooldown <= '0;
    end else begin
      frame_q <= frame_clk;
      fire_q  <= fire;
      if (fire_edge)     pending <= 1'b1;
      else if (spawn_en) pending <= 1'b0;
      if (serve)                          cooldown <= 4'(COOLDOWN);
      else if (move_en && cooldown != '0) cooldown <= cooldown - 4'd1;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot u_slot (
      .clk      (Clk),
      .reset    (Reset),
      .move     (move_en),
      .load     (load[g]),
      .load_x   (TankX),
      .load_y   (TankY),
      .load_sin (sin),
      .load_cos (cos),
      .active   (active[g]),
      .pos_x    (px[g]),
      .pos_y    (py[g])
    );
  end

  assign Bullet1X = px[0];
  assign Bullet2X = px[1];
  assign Bullet3X = px[2];
  assign Bullet1Y = py[0];
  assign Bullet2Y = py[1];
  assign Bullet3Y = py[2];
  assign Bullet1S = 10'(BULLET_SIZE);
  assign Bullet2S = 10'(BULLET_SIZE);
  assign Bullet3S = 10'(BULLET_SIZE);
  assign is_bullet1_active = active[0];
  assign is_bullet2_active = active[1];
  assign is_bullet3_active = active[2];

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with a scoreboard queue of expected outputs.
module tb_bullet_pool;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] TankX = 10'd320;
  logic [9:0] TankY = 10'd240;
  logic [7:0] sin = 8'd0;
  logic [7:0] cos = 8'd64;
  logic [9:0] Bullet1X, Bullet2X, Bullet3X;
  logic [9:0] Bullet1Y, Bullet2Y, Bullet3Y;
  logic [9:0] Bullet1S, Bullet2S, Bullet3S;
  logic       is_bullet1_active, is_bullet2_active, is_bullet3_active;
  logic [1:0] free_slots;

  bullet_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .TankX(TankX), .TankY(TankY), .sin(sin), .cos(cos),
    .Bullet1X(Bullet1X), .Bullet2X(Bullet2X), .Bullet3X(Bullet3X),
    .Bullet1Y(Bullet1Y), .Bullet2Y(Bullet2Y), .Bullet3Y(Bullet3Y),
    .Bullet1S(Bullet1S), .Bullet2S(Bullet2S), .Bullet3S(Bullet3S),
    .is_bullet1_active(is_bullet1_active), .is_bullet2_active(is_bullet2_active),
    .is_bullet3_active(is_bullet3_active), .free_slots(free_slots)
  );

  always #5 Clk = ~Clk;

  localparam int S_X1 = 0, S_Y1 = 1, S_X2 = 2, S_Y2 = 3, S_X3 = 4, S_Y3 = 5;
  localparam int S_A1 = 6, S_A2 = 7, S_A3 = 8, S_FREE = 9;
  localparam int S_S1 = 10, S_S2 = 11, S_S3 = 12;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_X1:    return 32'(Bullet1X);
      S_Y1:    return 32'(Bullet1Y);
      S_X2:    return 32'(Bullet2X);
      S_Y2:    return 32'(Bullet2Y);
      S_X3:    return 32'(Bullet3X);
      S_Y3:    return 32'(Bullet3Y);
      S_A1:    return 32'(is_bullet1_active);
      S_A2:    return 32'(is_bullet2_active);
      S_A3:    return 32'(is_bullet3_active);
      S_FREE:  return 32'(free_slots);
      S_S1:    return 32'(Bullet1S);
      S_S2:    return 32'(Bullet2S);
      default: return 32'(Bullet3S);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
    sb.push_back('{tag, sel, val});
  endtask

  task automatic compare();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    fire = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic fire_pulse();
    @(negedge Clk);
    fire = 1'b1;
    @(negedge Clk);
    fire = 1'b0;
  endtask

  // One frame: tick cycle, MOVE, SPAWN (mid-point), then results visible.
  task automatic run_frame(input bit with_fire, input bit mid_chk,
                           input logic mid_a1, input bit rst_spawn);
    @(negedge Clk);
    frame_clk = 1'b1;
    fire = with_fire;
    @(negedge Clk);
    frame_clk = 1'b0;
    fire = 1'b0;
    @(negedge Clk);
    if (mid_chk) begin
      push_exp("spawn_cycle_active1", S_A1, 32'(mid_a1));
      compare();
    end
    if (rst_spawn) Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    push_exp("rst_a1", S_A1, 0);
    push_exp("rst_a2", S_A2, 0);
    push_exp("rst_a3", S_A3, 0);
    push_exp("rst_free", S_FREE, 3);
    push_exp("rst_x1", S_X1, 0);
    push_exp("rst_y1", S_Y1, 0);
    push_exp("rst_s1", S_S1, 2);
    push_exp("rst_s2", S_S2, 2);
    push_exp("rst_s3", S_S3, 2);
    compare();

    // Basic spawn at tank centre, then one frame of motion along +X.
    run_frame(1, 1, 1'b0, 0);
    push_exp("spawn_a1", S_A1, 1);
    push_exp("spawn_x1", S_X1, 320);
    push_exp("spawn_y1", S_Y1, 240);
    push_exp("spawn_free", S_FREE, 2);
    compare();
    run_frame(0, 0, 1'b0, 0);
    push_exp("move_x1", S_X1, 324);
    push_exp("move_y1", S_Y1, 240);
    compare();

    // Two edges before a frame collapse to one; slots fill 1,2,3; fourth dropped.
    do_reset();
    fire_pulse();
    fire_pulse();
    run_frame(0, 0, 1'b0, 0);
    push_exp("collapse_a1", S_A1, 1);
    push_exp("collapse_a2", S_A2, 0);
    push_exp("collapse_free", S_FREE, 2);
    compare();
    repeat (9) run_frame(0, 0, 1'b0, 0);
    run_frame(1, 0, 1'b0, 0);
    push_exp("fill_a2", S_A2, 1);
    push_exp("fill_x2", S_X2, 320);
    push_exp("fill_x1_f10", S_X1, 360);
    push_exp("fill_free2", S_FREE, 1);
    compare();
    repeat (9) run_frame(0, 0, 1'b0, 0);
    run_frame(1, 0, 1'b0, 0);
    push_exp("fill_a3", S_A3, 1);
    push_exp("fill_y3", S_Y3, 240);
    push_exp("fill_free3", S_FREE, 0);
    compare();
    repeat (9) run_frame(0, 0, 1'b0, 0);
    run_frame(1, 0, 1'b0, 0);
    push_exp("full_free", S_FREE, 0);
    push_exp("full_x1", S_X1, 440);
    push_exp("full_x2", S_X2, 400);
    push_exp("full_x3", S_X3, 360);
    compare();

    // Second fire three frames later is dropped by cooldown and not carried over.
    do_reset();
    run_frame(1, 0, 1'b0, 0);
    run_frame(0, 0, 1'b0, 0);
    run_frame(0, 0, 1'b0, 0);
    run_frame(1, 0, 1'b0, 0);
    push_exp("cool_a1", S_A1, 1);
    push_exp("cool_a2", S_A2, 0);
    push_exp("cool_free", S_FREE, 2);
    compare();
    repeat (6) run_frame(0, 0, 1'b0, 0);
    push_exp("cool_dropped_a2", S_A2, 0);
    push_exp("cool_dropped_free", S_FREE, 2);
    compare();

    // Right edge on X.
    do_reset();
    TankX = 10'd638;
    run_frame(1, 0, 1'b0, 0);
    push_exp("edge_x1_spawn", S_X1, 638);
    push_exp("edge_a1_spawn", S_A1, 1);
    compare();
    run_frame(0, 0, 1'b0, 0);
`ifdef BULLET_BOUNCE_EN
    push_exp("bounce_x1", S_X1, 639);
    push_exp("bounce_a1", S_A1, 1);
    compare();
    run_frame(0, 0, 1'b0, 0);
    push_exp("bounce_x1_back", S_X1, 635);
    compare();
`else
    push_exp("exit_a1", S_A1, 0);
    push_exp("exit_x1_hold", S_X1, 638);
    push_exp("exit_free", S_FREE, 3);
    compare();
`endif

    // Top edge underflow on Y (sin=+1 moves upward).
    do_reset();
    TankX = 10'd320;
    TankY = 10'd2;
    cos = 8'd0;
    sin = 8'd64;
    run_frame(1, 0, 1'b0, 0);
    push_exp("yedge_y1_spawn", S_Y1, 2);
    compare();
    run_frame(0, 0, 1'b0, 0);
`ifdef BULLET_BOUNCE_EN
    push_exp("ybounce_y1", S_Y1, 0);
    push_exp("ybounce_a1", S_A1, 1);
    compare();
    run_frame(0, 0, 1'b0, 0);
    push_exp("ybounce_y1_back", S_Y1, 4);
    compare();
`else
    push_exp("yexit_a1", S_A1, 0);
    push_exp("yexit_y1_hold", S_Y1, 2);
    compare();
`endif

    // Lifetime expiry after 600 moves; slot reused in the same frame.
    do_reset();
    TankX = 10'd100;
    TankY = 10'd100;
    cos = 8'd0;
    sin = 8'd0;
    run_frame(1, 0, 1'b0, 0);
    repeat (599) run_frame(0, 0, 1'b0, 0);
    push_exp("life599_a1", S_A1, 1);
    compare();
    TankX = 10'd200;
    run_frame(1, 1, 1'b0, 0);
    push_exp("reuse_a1", S_A1, 1);
    push_exp("reuse_x1", S_X1, 200);
    push_exp("reuse_a2", S_A2, 0);
    push_exp("reuse_free", S_FREE, 2);
    compare();

    // Reset during SPAWN with a pending request abandons the spawn.
    do_reset();
    TankX = 10'd320;
    TankY = 10'd240;
    cos = 8'd64;
    run_frame(1, 0, 1'b0, 1);
    push_exp("rspawn_a1", S_A1, 0);
    push_exp("rspawn_free", S_FREE, 3);
    push_exp("rspawn_x1", S_X1, 0);
    push_exp("rspawn_y1", S_Y1, 0);
    compare();
    run_frame(0, 0, 1'b0, 0);
    push_exp("rspawn_next_a1", S_A1, 0);
    push_exp("rspawn_next_free", S_FREE, 3);
    compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
